// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: opcodes, instruction-class bit positions and the decoded bundle.
// The optional DECODE_MEXT_EN macro adds an M-extension flag to the bundle.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  // Bit positions inside the 7-bit types vector {R, I, L, S, J, B, U}
  localparam int T_R = 6;
  localparam int T_I = 5;
  localparam int T_L = 4;
  localparam int T_S = 3;
  localparam int T_J = 2;
  localparam int T_B = 1;
  localparam int T_U = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [6:0]            types;
    logic [XLEN-1:0]       imm;
`ifdef DECODE_MEXT_EN
    logic                  mext;
`endif
  } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32 immediate generator: picks the immediate format from the opcode
// and sign-extends it to XLEN; R-type and unknown opcodes yield zero.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, LOAD, JALR: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      STORE:              imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      BRANCH:             imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
      JAL:                imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
      LUI, AUIPC:         imm = {instr[31:12], 12'b0};
      default:            imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32 decode stage with a two-entry (main + skid) buffer and flush.
// Define DECODE_MEXT_EN to add the is_mext output flagging M-extension instructions.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int REG_FILE_DEPTH    = 32,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_instr,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [REG_FILE_ADDR_LEN-1:0] rs1,
  output logic [REG_FILE_ADDR_LEN-1:0] rs2,
  output logic [REG_FILE_ADDR_LEN-1:0] rd,
  output logic [6:0]                   opcode,
  output logic [2:0]                   funct3,
  output logic [6:0]                   funct7,
  output logic [6:0]                   types,
  output logic [XLEN-1:0]              imm
`ifdef DECODE_MEXT_EN
  ,
  output logic                         is_mext
`endif
);

  buf_state_e      state, state_next;
  decoded_t        dec, main_q, skid_q;
  logic [XLEN-1:0] dec_imm;
  logic            acc, pop;
  logic            load_main, load_skid, move_skid;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (dec_imm)
  );

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.opcode = in_instr[6:0];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    dec.imm    = dec_imm;
    case (in_instr[6:0])
      OP:         dec.types[T_R] = 1'b1;
      OP_IMM:     dec.types[T_I] = 1'b1;
      LOAD:       dec.types[T_L] = 1'b1;
      STORE:      dec.types[T_S] = 1'b1;
      JAL:        dec.types[T_J] = 1'b1;
      BRANCH:     dec.types[T_B] = 1'b1;
      LUI, AUIPC: dec.types[T_U] = 1'b1;
      JALR: begin
        // JALR is both an I-format instruction and a jump
        dec.types[T_I] = 1'b1;
        dec.types[T_J] = 1'b1;
      end
      default: dec.types = '0;
    endcase
`ifdef DECODE_MEXT_EN
    dec.mext = (in_instr[6:0] == OP) && (in_instr[31:25] == FUNCT7_MEXT);
`endif
  end

  // in_ready depends only on the state flop, never on out_ready, so it is a clean registered signal
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
        ONE: begin
          if (acc && !pop) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (acc && pop) begin
            load_main  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_next = ONE;
          move_skid  = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: the bundle registers are reset too, so every output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= dec;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= dec;
    end
  end

  assign out_pc = main_q.pc;
  assign rs1    = main_q.rs1;
  assign rs2    = main_q.rs2;
  assign rd     = main_q.rd;
  assign opcode = main_q.opcode;
  assign funct3 = main_q.funct3;
  assign funct7 = main_q.funct7;
  assign types  = main_q.types;
  assign imm    = main_q.imm;
`ifdef DECODE_MEXT_EN
  assign is_mext = main_q.mext;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode vectors, backpressure/flush
// sequences and a randomized run against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7, types;
  logic [2:0]  funct3;
`ifdef DECODE_MEXT_EN
  logic        is_mext;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .types     (types),
    .imm       (imm)
`ifdef DECODE_MEXT_EN
    ,
    .is_mext   (is_mext)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7, types;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        mext;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  types;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        mext;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode built directly from the ISA field layout using signed shifts.
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] top;
    logic r, i, l, st, j, b, u;
    s = instr;
    top = s >>> 31;
    e.pc = pc;
    e.rs1 = instr[19:15];
    e.rs2 = instr[24:20];
    e.rd = instr[11:7];
    e.opcode = instr[6:0];
    e.funct3 = instr[14:12];
    e.funct7 = instr[31:25];
    r  = (instr[6:0] == 7'h33);
    i  = (instr[6:0] == 7'h13) || (instr[6:0] == 7'h67);
    l  = (instr[6:0] == 7'h03);
    st = (instr[6:0] == 7'h23);
    j  = (instr[6:0] == 7'h6F) || (instr[6:0] == 7'h67);
    b  = (instr[6:0] == 7'h63);
    u  = (instr[6:0] == 7'h37) || (instr[6:0] == 7'h17);
    e.types = {r, i, l, st, j, b, u};
    if (i || l)  e.imm = s >>> 20;
    else if (st) e.imm = (top << 12) | (32'(instr[31:25]) << 5) | 32'(instr[11:7]);
    else if (b)  e.imm = (top << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5)
                       | (32'(instr[11:8]) << 1);
    else if (j)  e.imm = (top << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11)
                       | (32'(instr[30:21]) << 1);
    else if (u)  e.imm = instr & 32'hFFFF_F000;
    else         e.imm = 32'h0;
`ifdef DECODE_MEXT_EN
    e.mext = r && (instr[31:25] == 7'h01);
`else
    e.mext = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_bundle(input string tag, input exp_t e);
    check({tag, ".pc"},     out_pc, e.pc);
    check({tag, ".rs1"},    32'(rs1), 32'(e.rs1));
    check({tag, ".rs2"},    32'(rs2), 32'(e.rs2));
    check({tag, ".rd"},     32'(rd), 32'(e.rd));
    check({tag, ".opcode"}, 32'(opcode), 32'(e.opcode));
    check({tag, ".funct3"}, 32'(funct3), 32'(e.funct3));
    check({tag, ".funct7"}, 32'(funct7), 32'(e.funct7));
    check({tag, ".types"},  32'(types), 32'(e.types));
    check({tag, ".imm"},    imm, e.imm);
`ifdef DECODE_MEXT_EN
    check({tag, ".is_mext"}, 32'(is_mext), 32'(e.mext));
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1) w[31:25] = 7'h01;
    return w;
  endfunction

  vec_t vecs [12];
  exp_t q [$];
  exp_t ea, eb, ec;

  initial begin
    vecs[0]  = '{32'hFFF10093, 7'h20, 32'hFFFFFFFF, 5'd1,  5'd2, 5'd31, 1'b0}; // addi x1,x2,-1
    vecs[1]  = '{32'h00532423, 7'h08, 32'h00000008, 5'd8,  5'd6, 5'd5,  1'b0}; // sw x5,8(x6)
    vecs[2]  = '{32'hFFDFF06F, 7'h04, 32'hFFFFFFFC, 5'd0,  5'd31, 5'd29, 1'b0}; // jal x0,-4
    vecs[3]  = '{32'h000280E7, 7'h24, 32'h00000000, 5'd1,  5'd5, 5'd0,  1'b0}; // jalr x1,0(x5)
    vecs[4]  = '{32'h002081B3, 7'h40, 32'h00000000, 5'd3,  5'd1, 5'd2,  1'b0}; // add x3,x1,x2
    vecs[5]  = '{32'h022081B3, 7'h40, 32'h00000000, 5'd3,  5'd1, 5'd2,  1'b1}; // mul x3,x1,x2
    vecs[6]  = '{32'h123452B7, 7'h01, 32'h12345000, 5'd5,  5'd8, 5'd3,  1'b0}; // lui x5,0x12345
    vecs[7]  = '{32'hFFFFF097, 7'h01, 32'hFFFFF000, 5'd1,  5'd31, 5'd31, 1'b0}; // auipc x1,0xFFFFF
    vecs[8]  = '{32'hFF812083, 7'h10, 32'hFFFFFFF8, 5'd1,  5'd2, 5'd24, 1'b0}; // lw x1,-8(x2)
    vecs[9]  = '{32'hFE2088E3, 7'h02, 32'hFFFFFFF0, 5'd17, 5'd1, 5'd2,  1'b0}; // beq x1,x2,-16
    vecs[10] = '{32'hFFFFFFFF, 7'h00, 32'h00000000, 5'd31, 5'd31, 5'd31, 1'b0}; // unknown opcode
    vecs[11] = '{32'h7FF00013, 7'h20, 32'h000007FF, 5'd0,  5'd0, 5'd31, 1'b0}; // addi x0,x0,2047

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'hFFFFFFFF; in_pc = 32'hFFFFFFFF;

    // Reset state, observed while reset is asserted
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready), 32'd1);
    check("rst.out_pc",    out_pc, 32'd0);
    check("rst.fields",    {rs1, rs2, rd, opcode, funct3, funct7[4:0]}, 32'd0);
    check("rst.types",     32'(types), 32'd0);
    check("rst.imm",       imm, 32'd0);
`ifdef DECODE_MEXT_EN
    check("rst.is_mext",   32'(is_mext), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode table, streamed back to back with out_ready high
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      in_valid = 1'b1;
      in_instr = vecs[k].instr;
      in_pc    = 32'h1000 + 32'(k) * 4;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d.pc", k),    out_pc, 32'h1000 + 32'(k) * 4);
      check($sformatf("vec%0d.types", k), 32'(types), 32'(vecs[k].types));
      check($sformatf("vec%0d.imm", k),   imm, vecs[k].imm);
      check($sformatf("vec%0d.rd", k),    32'(rd), 32'(vecs[k].rd));
      check($sformatf("vec%0d.rs1", k),   32'(rs1), 32'(vecs[k].rs1));
      check($sformatf("vec%0d.rs2", k),   32'(rs2), 32'(vecs[k].rs2));
      check($sformatf("vec%0d.funct3", k), 32'(funct3), 32'(vecs[k].instr[14:12]));
`ifdef DECODE_MEXT_EN
      check($sformatf("vec%0d.is_mext", k), 32'(is_mext), 32'(vecs[k].mext));
`endif
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three offered with out_ready low, only two accepted
    ea = ref_decode(32'hFFF10093, 32'hA0);
    eb = ref_decode(32'h00532423, 32'hA4);
    ec = ref_decode(32'hFFDFF06F, 32'hA8);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'hA0;
    @(posedge clk); @(negedge clk);
    check("bp.ready_after1", 32'(in_ready), 32'd1);
    in_instr = 32'h00532423; in_pc = 32'hA4;
    @(posedge clk); @(negedge clk);
    check("bp.ready_full", 32'(in_ready), 32'd0);
    in_instr = 32'hFFDFF06F; in_pc = 32'hA8;
    @(posedge clk); @(negedge clk);
    check("bp.ready_held", 32'(in_ready), 32'd0);
    check_bundle("bp.hold_a", ea);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_bundle("bp.b", eb);
    check("bp.ready_reopen", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_bundle("bp.c", ec);
    @(posedge clk); @(negedge clk);
    check("bp.empty", 32'(out_valid), 32'd0);

    // Flush while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'hB0;
    @(posedge clk); @(negedge clk);
    in_pc = 32'hB4;
    @(posedge clk); @(negedge clk);
    check("fl.full", 32'(in_ready), 32'd0);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check("fl.out_valid", 32'(out_valid), 32'd0);
    check("fl.in_ready", 32'(in_ready), 32'd1);

    // Flush in ONE with a same-cycle offer: the offer is dropped
    in_valid = 1'b1; in_instr = 32'h000280E7; in_pc = 32'hC0;
    @(posedge clk); @(negedge clk);
    flush = 1'b1; in_pc = 32'hC4;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl1.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("fl1.dropped", 32'(out_valid), 32'd0);

    // Randomized run against a two-entry FIFO model
    q.delete();
    for (int c = 0; c < 800; c++) begin
      bit acc, pop;
      check("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("rnd.in_ready",  32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) check_bundle("rnd", q[0]);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(in_instr, in_pc));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
